// File: rtl/pattern_det.sv
// Serial pattern detector: compares a sliding window of accepted bits against a
// loadable pattern and emits a one-cycle registered pulse plus a saturating match count.
module pattern_det #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] DEF_PAT = 4'b1001,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seqIn,
    input  logic               seqValid,
    input  logic               cfgLoad,
    input  logic [PAT_LEN-1:0] cfgPat,
    input  logic               cntClr,
    output logic               detOut,
    output logic [CNT_W-1:0]   detCnt,
    output logic [PAT_LEN-1:0] curPat
);

    localparam int               FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [PAT_LEN-1:0] historyReg, historyNext, shifted;
    logic [FILL_W-1:0]  fillReg, fillNext, fillInc;
    logic [PAT_LEN-1:0] curPatReg, curPatNext;
    logic [CNT_W-1:0]   cntReg, cntNext;
    logic               detReg, match;

    // Window and fill as they would look if the current bit is accepted.
    assign shifted = {historyReg[PAT_LEN-2:0], seqIn};
    assign fillInc = (fillReg == FILL_MAX) ? FILL_MAX : fillReg + FILL_ONE;

    // A pending pattern load takes the edge, so the offered bit cannot match.
    assign match = seqValid && !cfgLoad && (fillInc == FILL_MAX) && (shifted == curPatReg);

    always_comb begin
        historyNext = historyReg;
        fillNext    = fillReg;
        curPatNext  = curPatReg;
        if (cfgLoad) begin
            curPatNext = cfgPat;
            fillNext   = '0;
        end else if (seqValid) begin
            historyNext = shifted;
            fillNext    = (match && OVERLAP == 0) ? '0 : fillInc;
        end
    end

    always_comb begin
        cntNext = cntReg;
        if (cntClr) begin
            cntNext = match ? CNT_ONE : '0;
        end else if (match && cntReg != CNT_MAX) begin
            cntNext = cntReg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            historyReg <= '0;
            fillReg    <= '0;
            curPatReg  <= DEF_PAT;
            cntReg     <= '0;
            detReg     <= 1'b0;
        end else begin
            historyReg <= historyNext;
            fillReg    <= fillNext;
            curPatReg  <= curPatNext;
            cntReg     <= cntNext;
            detReg     <= match;
        end
    end

    assign detOut = detReg;
    assign detCnt = cntReg;
    assign curPat = curPatReg;

endmodule

// File: tb/tb_pattern_det.sv
// Bench for pattern_det: three instances (overlap, non-overlap, 2-bit counter) share
// stimulus and are compared against a queue-based model of the detection rules.
module tb_pattern_det;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seqIn = 1'b0, seqValid = 1'b0, cfgLoad = 1'b0, cntClr = 1'b0;
    logic [3:0] cfgPat = 4'b0;

    logic       detA, detB, detC;
    logic [7:0] cntA, cntB;
    logic [1:0] cntC;
    logic [3:0] patA, patB, patC;

    logic       detW [3];
    logic [7:0] cntW [3];
    logic [3:0] patW [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: accepted bits since the last restart, most recent last.
    bit         mq   [3][$];
    logic [3:0] mPat [3];
    bit         mDet [3];
    int         mCnt [3];
    int         cntMax [3] = '{255, 255, 3};
    int         ovl    [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    pattern_det #(.PAT_LEN(4), .DEF_PAT(4'b1001), .OVERLAP(1), .CNT_W(8)) dutA (
        .clk(clk), .rst(rst), .seqIn(seqIn), .seqValid(seqValid), .cfgLoad(cfgLoad),
        .cfgPat(cfgPat), .cntClr(cntClr), .detOut(detA), .detCnt(cntA), .curPat(patA));
    pattern_det #(.PAT_LEN(4), .DEF_PAT(4'b1001), .OVERLAP(0), .CNT_W(8)) dutB (
        .clk(clk), .rst(rst), .seqIn(seqIn), .seqValid(seqValid), .cfgLoad(cfgLoad),
        .cfgPat(cfgPat), .cntClr(cntClr), .detOut(detB), .detCnt(cntB), .curPat(patB));
    pattern_det #(.PAT_LEN(4), .DEF_PAT(4'b1001), .OVERLAP(1), .CNT_W(2)) dutC (
        .clk(clk), .rst(rst), .seqIn(seqIn), .seqValid(seqValid), .cfgLoad(cfgLoad),
        .cfgPat(cfgPat), .cntClr(cntClr), .detOut(detC), .detCnt(cntC), .curPat(patC));

    assign detW[0] = detA;
    assign detW[1] = detB;
    assign detW[2] = detC;
    assign cntW[0] = cntA;
    assign cntW[1] = cntB;
    assign cntW[2] = {6'b0, cntC};
    assign patW[0] = patA;
    assign patW[1] = patB;
    assign patW[2] = patC;

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            mPat[k] = 4'b1001;
            mDet[k] = 1'b0;
            mCnt[k] = 0;
        end
    endtask

    // One clock cycle of stimulus; the model follows the rules at the rising edge.
    task automatic step(input bit v, input bit b, input bit ld = 1'b0,
                        input logic [3:0] p = 4'b0, input bit clr = 1'b0);
        bit m;
        @(negedge clk);
        seqValid = v; seqIn = b; cfgLoad = ld; cfgPat = p; cntClr = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m = 1'b0;
            if (ld) begin
                mPat[k] = p;
                mq[k].delete();
            end else if (v) begin
                mq[k].push_back(b);
                if (mq[k].size() > 4) void'(mq[k].pop_front());
                if (mq[k].size() == 4) begin
                    m = 1'b1;
                    for (int i = 0; i < 4; i++)
                        if (mq[k][i] != mPat[k][3-i]) m = 1'b0;
                end
                if (m && ovl[k] == 0) mq[k].delete();
            end
            mDet[k] = m;
            if (clr) mCnt[k] = m ? 1 : 0;
            else if (m && mCnt[k] < cntMax[k]) mCnt[k]++;
        end
        #1;
        cyc++;
        $display("cyc %0d v=%b b=%b ld=%b pat=%b clr=%b | det=%b%b%b cnt=%0d/%0d/%0d",
                 cyc, v, b, ld, p, clr, detA, detB, detC, cntA, cntB, cntC);
        seqValid = 1'b0; cfgLoad = 1'b0; cntClr = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (detW[k] !== 1'b0 || cntW[k] !== 8'd0 || patW[k] !== 4'b1001) begin
                errors++;
                $display("FAIL reset dut%0d: det=%b cnt=%0d pat=%b, expected det=0 cnt=0 pat=1001",
                         k, detW[k], cntW[k], patW[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        bit bits [7] = '{1, 0, 0, 1, 0, 0, 1};
        int pulses [3] = '{0, 0, 0};
        doReset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[i]);
            for (int k = 0; k < 3; k++) begin
                checks++;
                pulses[k] += int'(detW[k] === 1'b1);
                if (detW[k] !== mDet[k] || cntW[k] !== 8'(mCnt[k])) begin
                    errors++;
                    $display("FAIL stream dut%0d bit%0d: det=%b cnt=%0d, expected det=%b cnt=%0d",
                             k, i + 1, detW[k], cntW[k], mDet[k], mCnt[k]);
                end
            end
        end
        checks++;
        if (pulses[0] != 2 || cntA !== 8'd2 || pulses[1] != 1 || cntB !== 8'd1) begin
            errors++;
            $display("FAIL stream_totals: pulses=%0d/%0d cnt=%0d/%0d, expected pulses=2/1 cnt=2/1",
                     pulses[0], pulses[1], cntA, cntB);
        end
    endtask

    task automatic test_gaps();
        bit bits [4] = '{1, 0, 0, 1};
        doReset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[i]);
            for (int g = 0; g < 3; g++) begin
                step(1'b0, ~bits[i]);
                checks++;
                if (detA !== mDet[0] || cntA !== 8'(mCnt[0])) begin
                    errors++;
                    $display("FAIL gaps bit%0d gap%0d: det=%b cnt=%0d, expected det=%b cnt=%0d",
                             i + 1, g, detA, cntA, mDet[0], mCnt[0]);
                end
            end
        end
        checks++;
        if (cntA !== 8'd1 || detA !== 1'b0) begin
            errors++;
            $display("FAIL gaps_total: cnt=%0d det=%b, expected cnt=1 det=0", cntA, detA);
        end
    endtask

    task automatic test_cfg_load();
        doReset();
        step(1'b1, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (detW[k] !== mDet[k] || cntW[k] !== 8'(mCnt[k]) || patW[k] !== mPat[k]) begin
                    errors++;
                    $display("FAIL cfg_load dut%0d bit%0d: det=%b cnt=%0d pat=%b, expected det=%b cnt=%0d pat=%b",
                             k, i + 1, detW[k], cntW[k], patW[k], mDet[k], mCnt[k], mPat[k]);
                end
            end
        end
        checks++;
        if (cntA !== 8'd2 || cntB !== 8'd1 || patA !== 4'b1111) begin
            errors++;
            $display("FAIL cfg_load_total: cntA=%0d cntB=%0d pat=%b, expected 2 1 1111", cntA, cntB, patA);
        end
    endtask

    task automatic test_saturate();
        doReset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, (i % 3) == 2);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (detW[k] !== mDet[k] || cntW[k] !== 8'(mCnt[k])) begin
                    errors++;
                    $display("FAIL saturate dut%0d step%0d: det=%b cnt=%0d, expected det=%b cnt=%0d",
                             k, i, detW[k], cntW[k], mDet[k], mCnt[k]);
                end
            end
        end
        checks++;
        if (cntC !== 2'd3 || cntA !== 8'd5) begin
            errors++;
            $display("FAIL saturate_total: cntC=%0d cntA=%0d, expected 3 5", cntC, cntA);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
        checks++;
        if (cntC !== 2'd1 || cntA !== 8'd1 || detA !== 1'b1) begin
            errors++;
            $display("FAIL clear_on_match: cntC=%0d cntA=%0d det=%b, expected 1 1 1", cntC, cntA, detA);
        end
    endtask

    task automatic test_reset_mid();
        bit bits [4] = '{1, 0, 0, 1};
        for (int i = 0; i < 3; i++) step(1'b1, bits[i]);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checks++;
        if (detA !== 1'b0 || cntA !== 8'd0 || cntC !== 2'd0 || patA !== 4'b1001) begin
            errors++;
            $display("FAIL reset_mid_async: det=%b cntA=%0d cntC=%0d pat=%b, expected 0 0 0 1001",
                     detA, cntA, cntC, patA);
        end
        @(negedge clk);
        seqValid = 1'b1; seqIn = 1'b1; cfgLoad = 1'b1; cfgPat = 4'b0000; cntClr = 1'b1;
        @(negedge clk);
        seqValid = 1'b0; cfgLoad = 1'b0; cntClr = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[(i + 3) % 4]);
            checks++;
            if (detA !== mDet[0] || detA !== (i == 4) || cntA !== 8'(mCnt[0]) || patA !== 4'b1001) begin
                errors++;
                $display("FAIL reset_mid bit%0d: det=%b cnt=%0d pat=%b, expected det=%b cnt=%0d pat=1001",
                         i + 1, detA, cntA, patA, mDet[0], mCnt[0]);
            end
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 29) == 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (detW[k] !== mDet[k] || cntW[k] !== 8'(mCnt[k]) || patW[k] !== mPat[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: det=%b cnt=%0d pat=%b, expected det=%b cnt=%0d pat=%b",
                             k, cyc, detW[k], cntW[k], patW[k], mDet[k], mCnt[k], mPat[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_cfg_load();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_det.md
PATTERN_DET -- requirements
Module: pattern_det

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter DEF_PAT, default 4'b1001 (PAT_LEN bits), giving the pattern loaded at reset.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = history restarts after each match.
REQ-004 SHALL have parameter CNT_W, default 8, giving the match-counter width; legal range 1..32.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port seqIn, input, 1 bit: serial data bit.
REQ-008 SHALL have port seqValid, input, 1 bit: seqIn is accepted on a rising clk edge where seqValid=1.
REQ-009 SHALL have port cfgLoad, input, 1 bit: load request for a new pattern.
REQ-010 SHALL have port cfgPat, input, PAT_LEN bits: new pattern, sampled when cfgLoad=1; MSB is the first bit of the sequence.
REQ-011 SHALL have port cntClr, input, 1 bit: synchronous clear of the match counter.
REQ-012 SHALL have port detOut, output, 1 bit: registered match pulse.
REQ-013 SHALL have port detCnt, output, CNT_W bits: saturating count of matches.
REQ-014 SHALL have port curPat, output, PAT_LEN bits: the active pattern register.

Function
REQ-015 SHALL keep history, a PAT_LEN-bit shift register: on each accepted bit, shift left and insert seqIn at the LSB.
REQ-016 SHALL keep fill, a counter of accepted bits since the last restart, saturating at PAT_LEN.
REQ-017 SHALL declare a match on an accepted edge when fill (including the current bit) reaches PAT_LEN and the updated history equals curPat.
REQ-018 SHALL assert detOut for exactly one cycle, in the cycle after the edge that accepted the last pattern bit (Moore, latency 1).
REQ-019 SHALL drive detOut to 0 in every other cycle, including cycles with seqValid=0.
REQ-020 SHALL allow back-to-back detOut pulses when successive accepted bits each complete a match (OVERLAP=1 only).
REQ-021 SHALL, with OVERLAP=0, set fill to 0 on a match edge, so no bit of the matched window contributes to the next match.
REQ-022 SHALL, with OVERLAP=1, leave fill at PAT_LEN after a match, so the sliding window continues.
REQ-023 SHALL, on cfgLoad=1, load curPat from cfgPat, set fill to 0, and suppress any match on that edge.
REQ-024 SHALL give cfgLoad priority when cfgLoad and seqValid are both 1: the bit is dropped and not counted.
REQ-025 SHALL increment detCnt by 1 per match and hold it at 2^CNT_W-1 once saturated, with no wrap.
REQ-026 SHALL apply cntClr on the same edge: detCnt becomes 0; if a match also occurs on that edge, detCnt becomes 1.
REQ-027 SHALL leave cntClr with no effect on history, fill, curPat or detOut.
REQ-028 SHALL treat the all-zero pattern like any other pattern; fill gating prevents a match on reset-cleared history.

Reset
REQ-029 SHALL, while rst=1, immediately and independently of clk force: detOut=0, detCnt=0, fill=0, history=0, curPat=DEF_PAT.
REQ-030 SHALL discard a partially received pattern if rst is asserted mid-sequence; detection restarts from fill=0 on the first accepted bit after release.
REQ-031 SHALL ignore seqValid, cfgLoad and cntClr while rst=1.

Verification
REQ-032 SHALL cover: defaults, OVERLAP=1, bits 1,0,0,1,0,0,1 every cycle -> detOut pulses after bit 4 and bit 7; detCnt=2.
REQ-033 SHALL cover: OVERLAP=0, same stream -> single pulse after bit 4; detCnt=1.
REQ-034 SHALL cover: bits 1,0,0,1 with seqValid=0 gaps between them -> one pulse, one cycle after the 4th accepted edge; no pulse during gaps.
REQ-035 SHALL cover: cfgLoad with cfgPat=4'b1111 together with a valid bit, then stream 1,1,1,1,1 -> dropped bit not counted; OVERLAP=1 gives pulses after bits 4 and 5.
REQ-036 SHALL cover: CNT_W=2, five matches -> detCnt sticks at 3; cntClr on a match edge -> detCnt=1.
REQ-037 SHALL cover: rst pulse between bits 3 and 4 of 1001 -> detOut, detCnt and fill are 0 without a clk edge, and there is no pulse until four more matching bits are accepted.
